// File: rtl/bot_update_responder.sv
// CPU-side consumer of the Rojobot update handshake: snapshots bot info on the
// update flag, pulses the acknowledge, and offers each snapshot through a one-entry buffer.
module bot_update_responder #(
    parameter int unsigned INFO_W     = 32,
    parameter int unsigned ACK_CYCLES = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              bot_update_sync_i,
    input  logic [INFO_W-1:0] bot_info_i,
    output logic              int_ack_o,
    output logic [INFO_W-1:0] info_data_o,
    output logic              info_valid_o,
    input  logic              info_ready_i,
    output logic [CNT_W-1:0]  update_count_o,
    output logic              overrun_o,
    input  logic              overrun_clr_i
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StAck  = 1'b1;

    localparam logic [3:0] AckLast = 4'(ACK_CYCLES - 1);

    logic [0:0]        state_q, state_d;
    logic [3:0]        ack_cnt_q, ack_cnt_d;
    logic [INFO_W-1:0] info_data_q, info_data_d;
    logic              info_valid_q, info_valid_d;
    logic [CNT_W-1:0]  update_count_q, update_count_d;
    logic              overrun_q, overrun_d;

    logic capture;
    logic consume;

    // The update flag is only looked at in IDLE; while acking it is known to be clearing.
    assign capture = (state_q == StIdle) && bot_update_sync_i;
    assign consume = info_valid_q && info_ready_i;

    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        case (state_q)
            StIdle: begin
                if (bot_update_sync_i) begin
                    state_d   = StAck;
                    ack_cnt_d = 4'd0;
                end
            end
            StAck: begin
                if (ack_cnt_q == AckLast) begin
                    state_d   = StIdle;
                    ack_cnt_d = 4'd0;
                end else begin
                    ack_cnt_d = ack_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d   = StIdle;
                ack_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        info_data_d    = info_data_q;
        info_valid_d   = info_valid_q;
        update_count_d = update_count_q;
        overrun_d      = overrun_q;

        if (consume) begin
            info_valid_d = 1'b0;
        end
        if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end
        if (capture) begin
            info_data_d    = bot_info_i;
            info_valid_d   = 1'b1;
            update_count_d = update_count_q + 1'b1;
            // Overwriting an entry nobody took; a set beats a simultaneous clear.
            if (info_valid_q && !info_ready_i) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            ack_cnt_q      <= 4'd0;
            info_data_q    <= '0;
            info_valid_q   <= 1'b0;
            update_count_q <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ack_cnt_q      <= ack_cnt_d;
            info_data_q    <= info_data_d;
            info_valid_q   <= info_valid_d;
            update_count_q <= update_count_d;
            overrun_q      <= overrun_d;
        end
    end

    // Pure state decode so the acknowledge cannot glitch on input activity.
    assign int_ack_o      = (state_q == StAck);
    assign info_data_o    = info_data_q;
    assign info_valid_o   = info_valid_q;
    assign update_count_o = update_count_q;
    assign overrun_o      = overrun_q;

endmodule
